// File: rtl/jtpang_gfx_arb_if.sv
// ----------------------------------------------------------------------------
// jtpang_gfx_arb_if
// Bundle of the graphics ROM arbiter's client and SDRAM-slot signals.
//
//   obj_cs / obj_addr   -> arbiter   object line drawer request
//   obj_data / obj_ok   <- arbiter   latched data for the object client
//   chr_cs / chr_addr   -> arbiter   character fetcher request
//   chr_data / chr_ok   <- arbiter   latched data for the character client
//   rom_cs / rom_addr   <- arbiter   request to the SDRAM ROM slot
//   rom_data / rom_ok   -> arbiter   SDRAM ROM slot response
//
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (clients + SDRAM slot)
// ----------------------------------------------------------------------------
interface jtpang_gfx_arb_if #(
    parameter int AW = 17,
    parameter int DW = 32
);
    logic          obj_cs;
    logic [AW-1:0] obj_addr;
    logic [DW-1:0] obj_data;
    logic          obj_ok;

    logic          chr_cs;
    logic [AW-1:0] chr_addr;
    logic [DW-1:0] chr_data;
    logic          chr_ok;

    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_ok;

    modport slave (
        input  obj_cs, obj_addr,
        output obj_data, obj_ok,
        input  chr_cs, chr_addr,
        output chr_data, chr_ok,
        output rom_cs, rom_addr,
        input  rom_data, rom_ok
    );

    modport master (
        output obj_cs, obj_addr,
        input  obj_data, obj_ok,
        output chr_cs, chr_addr,
        input  chr_data, chr_ok,
        input  rom_cs, rom_addr,
        output rom_data, rom_ok
    );
endinterface

// File: rtl/jtpang_gfx_arb.sv
// ----------------------------------------------------------------------------
// jtpang_gfx_arb
// Shares one 32-bit graphics ROM port between the object line drawer (obj)
// and the character/tile fetcher (chr). Each client gets a private
// cs/addr/data/ok port; requests are serialised onto the SDRAM ROM slot and
// the returned word is held per client until that client moves to a new
// address.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : jtpang_gfx_arb_if.slave (client ports and SDRAM slot port)
//
// Optional feature:
//   JTPANG_ARB_RR_EN  defined   -> round-robin on contention
//                     undefined -> fixed priority, obj beats chr
// ----------------------------------------------------------------------------
module jtpang_gfx_arb #(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    jtpang_gfx_arb_if.slave  bus
);
    // Client index 0 = obj, 1 = chr
    localparam int NCLI = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic            r_rom_cs, w_rom_cs_next;
    logic [AW-1:0]   r_rom_addr, w_rom_addr_next;
    logic            r_winner, w_winner_next;   // 1 = chr owns the slot
    logic            w_done;
    logic            w_grant;                   // 1 = chr wins this arbitration
`ifdef JTPANG_ARB_RR_EN
    logic            r_last, w_last_next;       // 1 = chr was served last
`endif

    logic [NCLI-1:0] w_cs;
    logic [NCLI-1:0] w_hit;
    logic [NCLI-1:0] w_pend;
    logic [NCLI-1:0] w_store;
    logic [AW-1:0]   w_addr [NCLI];
    logic [DW-1:0]   w_data [NCLI];

    assign w_cs      = {bus.chr_cs, bus.obj_cs};
    assign w_addr[0] = bus.obj_addr;
    assign w_addr[1] = bus.chr_addr;

    // The completing transaction always lands in the client that won it,
    // even if that client has since moved on: the word is filed under the
    // address that was actually fetched, so ok stays low for a new address.
    assign w_store = w_done ? (r_winner ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------------------------
    // Per-client data latch, served address and valid flag
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCLI; gi++) begin : g_cli
            logic          r_valid;
            logic [AW-1:0] r_served;
            logic [DW-1:0] r_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid  <= 1'b0;
                    r_served <= '0;
                    r_data   <= '0;
                end else if (w_store[gi]) begin
                    r_data   <= bus.rom_data;
                    r_served <= r_rom_addr;
                    r_valid  <= 1'b1;
                end else if (!w_cs[gi]) begin
                    // dropping cs invalidates the held word
                    r_valid  <= 1'b0;
                end
            end

            assign w_hit[gi]  = r_valid && (w_addr[gi] == r_served);
            assign w_pend[gi] = w_cs[gi] && !w_hit[gi];
            assign w_data[gi] = r_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = w_pend[1] && !w_pend[0];
`ifdef JTPANG_ARB_RR_EN
        if (&w_pend) begin
            w_grant = !r_last;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Slot FSM: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_rom_cs_next   = r_rom_cs;
        w_rom_addr_next = r_rom_addr;
        w_winner_next   = r_winner;
        w_done          = 1'b0;
`ifdef JTPANG_ARB_RR_EN
        w_last_next     = r_last;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|w_pend) begin
                    w_rom_cs_next   = 1'b1;
                    w_rom_addr_next = w_grant ? w_addr[1] : w_addr[0];
                    w_winner_next   = w_grant;
`ifdef JTPANG_ARB_RR_EN
                    w_last_next     = w_grant;
`endif
                    w_state_next    = ST_ISSUE;
                end else begin
                    w_rom_cs_next   = 1'b0;
                end
            end
            ST_ISSUE: begin
                // rom_ok here may still belong to the previous address
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.rom_ok) begin
                    w_done        = 1'b1;
                    w_rom_cs_next = 1'b0;
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_rom_cs_next = 1'b0;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_winner   <= 1'b0;
`ifdef JTPANG_ARB_RR_EN
            r_last     <= 1'b1;     // obj wins the first contention
`endif
        end else begin
            r_state    <= w_state_next;
            r_rom_cs   <= w_rom_cs_next;
            r_rom_addr <= w_rom_addr_next;
            r_winner   <= w_winner_next;
`ifdef JTPANG_ARB_RR_EN
            r_last     <= w_last_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rom_cs   = r_rom_cs;
    assign bus.rom_addr = r_rom_addr;
    assign bus.obj_data = w_data[0];
    assign bus.chr_data = w_data[1];
    assign bus.obj_ok   = w_cs[0] && w_hit[0];
    assign bus.chr_ok   = w_cs[1] && w_hit[1];

endmodule
